// File: rtl/ssg_pkg.sv
// ssg_pkg: shared seven-segment constants and hex glyph lookup
package ssg_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  function automatic logic [6:0] ssg_hex(input logic [3:0] v);
    return SEG_HEX[v];
  endfunction
endpackage

// File: rtl/ssg_hex_decode.sv
// ssg_hex_decode: nibble to active-low g..a segment pattern
module ssg_hex_decode
  import ssg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = ssg_hex(i_nib);
endmodule

// File: rtl/ssg_scan_driver.sv
// ssg_scan_driver: time-multiplexed common-anode seven-segment scanner
// with blanking, blink, leading-zero suppression and frame-synchronous updates
module ssg_scan_driver
  import ssg_pkg::*;
#(
  parameter int NDIGITS    = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int GUARD      = 2,
  parameter int BLINK_LOG2 = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic [NDIGITS-1:0]     dp,
  input  logic [NDIGITS-1:0]     en,
  input  logic [NDIGITS-1:0]     blink,
  input  logic                   lz_blank,
  input  logic                   load,
  output logic [6:0]             seg,
  output logic                   seg_dp,
  output logic [NDIGITS-1:0]     an,
  output logic                   frame_done
);
  localparam int DIVW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int DW   = NDIGITS > 1 ? $clog2(NDIGITS) : 1;
  localparam int SW   = 7*NDIGITS + 1;
  logic [SW-1:0]         w_in, r_pend, r_act;
  logic [DIVW-1:0]       r_div;
  logic [DW-1:0]         r_digit;
  logic [BLINK_LOG2:0]   r_fcnt;
  logic [4*NDIGITS-1:0]  w_val;
  logic [NDIGITS-1:0]    w_dp, w_en, w_blink, w_lz, w_blank;
  logic [3:0]            w_nibs [NDIGITS];
  logic [6:0]            w_hex;
  logic                  w_lzb, w_zrun, w_wrap, w_fend, w_guard, w_off;
  assign w_in = {lz_blank, blink, en, dp, value};
  assign {w_lzb, w_blink, w_en, w_dp, w_val} = r_act;
  assign w_wrap = r_div == DIVW'(SCAN_DIV - 1);
  assign w_fend = w_wrap && r_digit == DW'(NDIGITS - 1);
  assign frame_done = w_fend;
  assign w_guard = r_div < DIVW'(GUARD);
  // A digit is a leading zero only while every digit above it is also zero
  always_comb begin
    w_lz = '0;
    w_zrun = w_lzb;
    for (int i = 0; i < NDIGITS; i++) w_nibs[i] = w_val[4*i +: 4];
    for (int i = NDIGITS - 1; i > 0; i--) begin
      w_zrun = w_zrun && (w_val[4*i +: 4] == 4'h0);
      w_lz[i] = w_zrun;
    end
  end
  assign w_blank = ~w_en | (w_blink & {NDIGITS{r_fcnt[BLINK_LOG2]}}) | w_lz;
  assign w_off = w_guard || w_blank[r_digit];
  ssg_hex_decode u_dec (.i_nib(w_nibs[r_digit]), .o_seg(w_hex));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div   <= '0;
      r_digit <= '0;
      r_fcnt  <= '0;
      r_pend  <= '0;
      r_act   <= '0;
      an      <= '1;
      seg     <= SEG_BLANK;
      seg_dp  <= 1'b1;
    end else begin
      r_div <= w_wrap ? '0 : r_div + 1'b1;
      if (w_wrap) r_digit <= r_digit == DW'(NDIGITS - 1) ? '0 : r_digit + 1'b1;
      if (load) r_pend <= w_in;
      if (w_fend) begin
        r_act  <= load ? w_in : r_pend;
        r_fcnt <= r_fcnt + 1'b1;
      end
      an     <= w_guard ? '1 : ~(NDIGITS'(1) << r_digit);
      seg    <= w_off ? SEG_BLANK : w_hex;
      seg_dp <= w_off || !w_dp[r_digit];
    end
  end
endmodule

// File: tb/tb_ssg_scan_driver.sv
// tb_ssg_scan_driver: directed self-checking bench for a 4-digit, 4-cycle-slot scanner
module tb_ssg_scan_driver;
  logic        clk = 0, rst = 1, lz_blank = 0, load = 0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0, en = '0, blink = '0, an;
  logic [6:0]  seg;
  logic        seg_dp, frame_done;
  int          n_cmp = 0, n_err = 0;
  ssg_scan_driver #(.NDIGITS(4), .SCAN_DIV(4), .GUARD(1), .BLINK_LOG2(1)) dut (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .en(en), .blink(blink),
    .lz_blank(lz_blank), .load(load), .seg(seg), .seg_dp(seg_dp), .an(an),
    .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
    load = 0;
  endtask
  // Runs one frame starting just after a frame-end edge; es packs {d3,d2,d1,d0} glyphs
  task automatic run_frame(input string name, input logic [27:0] es, input logic [3:0] edp, input int ld_at);
    for (int j = 0; j < 16; j++) begin
      int d, v;
      logic [3:0] ea;
      if (j == ld_at) load = 1;
      step;
      d = j / 4;
      v = j % 4;
      ea = v == 0 ? 4'hF : ~(4'b0001 << d);
      check($sformatf("%s an j=%0d", name, j), 7'(an), 7'(ea));
      check($sformatf("%s seg j=%0d", name, j), seg, v == 0 ? 7'h7F : es[d*7 +: 7]);
      check($sformatf("%s dp j=%0d", name, j), 7'(seg_dp), v == 0 ? 7'd1 : 7'(edp[d]));
      check($sformatf("%s fd j=%0d", name, j), 7'(frame_done), 7'(j == 14));
    end
  endtask
  initial begin
    step;
    step;
    check("reset an", 7'(an), 7'hF);
    check("reset seg", seg, 7'h7F);
    check("reset dp", 7'(seg_dp), 7'd1);
    check("reset fd", 7'(frame_done), 7'd0);
    rst = 0;
    value = 16'h12AF; en = 4'hF;
    run_frame("f0", {4{7'h7F}}, 4'hF, 0);
    value = 16'h0005; lz_blank = 1;
    run_frame("f1", {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF, 5);
    lz_blank = 0;
    run_frame("f2", {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'hF, 15);
    blink = 4'b0001; dp = 4'b0010;
    run_frame("f3", {7'h40, 7'h40, 7'h40, 7'h12}, 4'hF, 15);
    run_frame("f4", {7'h40, 7'h40, 7'h40, 7'h12}, 4'b1101, -1);
    run_frame("f5", {7'h40, 7'h40, 7'h40, 7'h12}, 4'b1101, -1);
    run_frame("f6", {7'h40, 7'h40, 7'h40, 7'h7F}, 4'b1101, -1);
    run_frame("f7", {7'h40, 7'h40, 7'h40, 7'h7F}, 4'b1101, -1);
    en = 4'b1101;
    run_frame("f8", {7'h40, 7'h40, 7'h40, 7'h12}, 4'b1101, 15);
    run_frame("f9", {7'h40, 7'h40, 7'h7F, 7'h12}, 4'hF, -1);
    for (int i = 0; i < 6; i++) step;
    check("pre-rst an", 7'(an), 7'hD);
    rst = 1;
    #1;
    check("mid-rst an", 7'(an), 7'hF);
    check("mid-rst seg", seg, 7'h7F);
    check("mid-rst dp", 7'(seg_dp), 7'd1);
    check("mid-rst fd", 7'(frame_done), 7'd0);
    step;
    step;
    rst = 0;
    run_frame("post-rst", {4{7'h7F}}, 4'hF, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
